logic_op_arbiter: RTL and testbench
===================================

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, indexed [16:1] on all data ports.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  requester valid; held until granted.
REQ-005 A0, B0, A1, B1  input  16 each  operands of requester 0/1, stable while reqN high.
REQ-006 op0, op1  input  2 each  operation code per requester: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse; operands of that requester accepted at this edge.
REQ-008 out  output  16  registered result of the accepted operation.
REQ-009 out_valid  output  1  out holds an unconsumed result.
REQ-010 out_id  output  1  requester index owning out (0 or 1).
REQ-011 out_ready  input  1  consumer accepts out when out_valid and out_ready both high.
REQ-012 op_count  output  8  count of results consumed, wraps 255 -> 0.

Function
REQ-013 Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 Slot free in a cycle when state is EMPTY, or state is FULL and out_ready=1.
REQ-015 Grant issued only when slot free and at least one reqN high; at most one gntN high per cycle.
REQ-016 Round-robin: pointer last holds index of last granted requester; on both requests, grant requester != last; on single request, grant it regardless of last.
REQ-017 last updates only on a grant; last resets to 1 so requester 0 wins the first tie.
REQ-018 gntN combinational from current state, reqN and last; asserted in the same cycle the acceptance occurs (gnt acts as ready).
REQ-019 On grant of N at edge k: out <= bitwise f(AN,BN) per opN for all 16 bits; out_id <= N; out_valid=1 from edge k; latency request-to-result 1 cycle.
REQ-020 XNOR result is bitwise complement of XOR; no carry or cross-bit interaction for any op.
REQ-021 FULL with out_ready=1 and a grant: old result consumed and new result loaded at the same edge; out_valid stays 1 (back-to-back, one result per cycle).
REQ-022 FULL with out_ready=1 and no request: out_valid <= 0 (-> EMPTY); out holds its last value.
REQ-023 FULL with out_ready=0: out, out_id, out_valid held; no grant regardless of requests.
REQ-024 op_count increments by 1 at each edge where out_valid and out_ready both high; 255 + 1 -> 0.
REQ-025 out_ready while EMPTY is ignored; no count change.
REQ-026 Requester dropping reqN before grant: no effect on state; no result produced.

Reset
REQ-027 rst_n low asynchronously forces: out=16'h0000, out_valid=0, out_id=0, op_count=0, last=1, state EMPTY.
REQ-028 gnt0, gnt1 are 0 while rst_n low; a pending result is discarded on reset mid-operation.
REQ-029 First grant possible at the first rising edge with rst_n high.

Verification
REQ-030 Single op: req0=1, A0=16'hF0F0, B0=16'hFF00, op0=10, out_ready=1 -> gnt0 pulse, next cycle out=16'h0FF0, out_valid=1, out_id=0; op_count=1 one edge later.
REQ-031 Op coverage: A=16'hAAAA, B=16'h5A5A via requester 1 for op 00/01/10/11 -> out 16'h0A0A, 16'hFAFA, 16'hF0F0, 16'h0F0F.
REQ-032 Fairness: req0=req1=1 held, out_ready=1 for 6 cycles after reset -> grants 0,1,0,1,0,1; out_id alternates; op_count=6 at end.
REQ-033 Backpressure: result FULL, out_ready=0 for 3 cycles with req1=1 -> no gnt1, out/out_id stable; out_ready=1 -> consume and gnt1 same cycle, out_valid stays 1.
REQ-034 Wrap and reset: 256 consumed results -> op_count=0; assert rst_n=0 mid-cycle while FULL -> out_valid=0, out=16'h0000 immediately, without a clock edge.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin arbiter with one bitwise logic unit and a single
// registered result slot. A requester is accepted in the same cycle its gnt is high.
module logic_op_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [16:1] A0,
    input  logic [16:1] B0,
    input  logic [16:1] A1,
    input  logic [16:1] B1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [16:1] out,
    output logic        out_valid,
    output logic        out_id,
    input  logic        out_ready,
    output logic [7:0]  op_count
);

    // Handshakes: an input transfer happens at an edge where reqN && gntN (gnt is
    // the ready); an output transfer happens at an edge where out_valid && out_ready.
    // reqN and its operands must stay stable until granted.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last;
    logic        slot_free;
    logic        pick1;
    logic        consume;
    logic [16:1] result;

    function automatic logic [16:1] logic_op(input logic [16:1] a,
                                             input logic [16:1] b,
                                             input logic [1:0]  op);
        logic [16:1] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a ^ b);
        endcase
        return r;
    endfunction

    always_comb begin
        slot_free  = (state == EMPTY) || out_ready;
        // Requester 1 wins a tie only when requester 0 was served last.
        pick1      = req1 && (!req0 || !last);
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_next = state;
        if (rst_n && slot_free) begin
            gnt0 = req0 && !pick1;
            gnt1 = pick1;
        end
        case (state)
            EMPTY: if (gnt0 || gnt1) state_next = FULL;
            FULL:  if (out_ready && !gnt0 && !gnt1) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign consume   = (state == FULL) && out_ready;
    assign result    = gnt1 ? logic_op(A1, B1, op1) : logic_op(A0, B0, op0);
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out      <= 16'h0000;
            out_id   <= 1'b0;
            last     <= 1'b1;
            op_count <= 8'd0;
        end else begin
            state <= state_next;
            if (gnt0 || gnt1) begin
                out    <= result;
                out_id <= gnt1;
                last   <= gnt1;
            end
            if (consume) op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: hand-computed results, grant order,
// backpressure, counter wrap and asynchronous reset.
module tb_logic_op_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [16:1] A0, B0, A1, B1;
    logic [1:0]  op0, op1;
    logic        gnt0, gnt1;
    logic [16:1] out;
    logic        out_valid, out_id;
    logic        out_ready;
    logic [7:0]  op_count;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] cov_exp [4];

    logic_op_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .A0        (A0),
        .B0        (B0),
        .A1        (A1),
        .B1        (B1),
        .op0       (op0),
        .op1       (op1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .out       (out),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_ready (out_ready),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cov_exp[0] = 16'h0A0A;
        cov_exp[1] = 16'hFAFA;
        cov_exp[2] = 16'hF0F0;
        cov_exp[3] = 16'h0F0F;

        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        A0 = 16'hF0F0; B0 = 16'hFF00; op0 = 2'b10;
        A1 = 16'hAAAA; B1 = 16'h5A5A; op1 = 2'b00;
        out_ready = 1'b1;

        // Reset state, grants suppressed while in reset
        step();
        check("rst_out", out, 16'h0000);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_id", 16'(out_id), 16'h0);
        check("rst_count", 16'(op_count), 16'h0);
        check("rst_gnt0", 16'(gnt0), 16'h0);
        rst_n = 1'b1;
        #1;

        // Single XOR op via requester 0
        check("single_gnt0", 16'(gnt0), 16'h1);
        check("single_gnt1", 16'(gnt1), 16'h0);
        step();
        req0 = 1'b0;
        check("single_out", out, 16'h0FF0);
        check("single_valid", 16'(out_valid), 16'h1);
        check("single_id", 16'(out_id), 16'h0);
        check("single_count0", 16'(op_count), 16'h0);
        #1;
        check("single_nognt", 16'(gnt0), 16'h0);
        step();
        check("single_count1", 16'(op_count), 16'h1);
        check("single_empty", 16'(out_valid), 16'h0);
        check("single_hold", out, 16'h0FF0);

        // All four ops via requester 1, back to back
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op1 = 2'(k);
            #1;
            check("cov_gnt1", 16'(gnt1), 16'h1);
            step();
            check("cov_out", out, cov_exp[k]);
            check("cov_id", 16'(out_id), 16'h1);
            check("cov_valid", 16'(out_valid), 16'h1);
        end
        req1 = 1'b0;
        step();
        check("cov_count", 16'(op_count), 16'd5);
        check("cov_empty", 16'(out_valid), 16'h0);

        // Fairness after a fresh reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        A0 = 16'h1234; B0 = 16'h00FF; op0 = 2'b00;
        A1 = 16'hAAAA; B1 = 16'h5A5A; op1 = 2'b01;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("fair_gnt0", 16'(gnt0), (i % 2 == 0) ? 16'h1 : 16'h0);
            check("fair_gnt1", 16'(gnt1), (i % 2 == 1) ? 16'h1 : 16'h0);
            step();
            check("fair_id", 16'(out_id), 16'(i % 2));
            check("fair_out", out, (i % 2 == 1) ? 16'hFAFA : 16'h0034);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("fair_count5", 16'(op_count), 16'd5);
        step();
        check("fair_count6", 16'(op_count), 16'd6);

        // Backpressure
        out_ready = 1'b0;
        A0 = 16'hF0F0; B0 = 16'hFF00; op0 = 2'b10;
        req0 = 1'b1;
        #1;
        check("bp_gnt0_empty", 16'(gnt0), 16'h1);
        step();
        req0 = 1'b0;
        req1 = 1'b1; op1 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_nogrant", 16'(gnt1), 16'h0);
            step();
            check("bp_out", out, 16'h0FF0);
            check("bp_id", 16'(out_id), 16'h0);
            check("bp_valid", 16'(out_valid), 16'h1);
            check("bp_count", 16'(op_count), 16'd6);
        end
        out_ready = 1'b1;
        #1;
        check("bp_gnt1", 16'(gnt1), 16'h1);
        step();
        req1 = 1'b0;
        check("bp_out2", out, 16'h0F0F);
        check("bp_id2", 16'(out_id), 16'h1);
        check("bp_valid2", 16'(out_valid), 16'h1);
        check("bp_count7", 16'(op_count), 16'd7);
        step();
        check("bp_count8", 16'(op_count), 16'd8);
        check("bp_empty", 16'(out_valid), 16'h0);

        // Counter wrap: 248 more results
        req0 = 1'b1;
        for (int i = 0; i < 248; i++) step();
        req0 = 1'b0;
        check("wrap_255", 16'(op_count), 16'd255);
        step();
        check("wrap_0", 16'(op_count), 16'd0);

        // Asynchronous reset while FULL
        req0 = 1'b1;
        step();
        step();
        req0 = 1'b0; out_ready = 1'b0;
        check("pre_rst_valid", 16'(out_valid), 16'h1);
        check("pre_rst_count", 16'(op_count), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", out, 16'h0000);
        check("arst_valid", 16'(out_valid), 16'h0);
        check("arst_count", 16'(op_count), 16'd0);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("arst_gnt0", 16'(gnt0), 16'h0);
        check("arst_gnt1", 16'(gnt1), 16'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_tie0", 16'(gnt0), 16'h1);
        check("post_rst_tie1", 16'(gnt1), 16'h0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        check("post_rst_id", 16'(out_id), 16'h0);
        check("post_rst_valid", 16'(out_valid), 16'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
